// File: rtl/time_report_tx.sv
// Time report UART transmitter: snapshots the displayed time and sends it
// to the PC as "Xhh:mm:ss.cc\r\n" over 8N1. Option: PERIODIC_REPORT_EN.
module time_report_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_send,
    input  logic       i_mode,
    input  logic [6:0] i_hour,
    input  logic [6:0] i_min,
    input  logic [6:0] i_sec,
    input  logic [6:0] i_msec,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0] LAST_IDX = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          tx_q, tx_d;

    logic          mode_q;
    logic [6:0]    hour_q, min_q, sec_q, msec_q;

    logic          start_req;
    logic          accept;
    logic          cnt_last;
    logic [2:0]    nxt_bit;
    logic [7:0]    cur_byte;
    logic [15:0]   hh, mm, ss, cc;

    // Two ASCII digits of a field; anything above 99 reads as "99".
    function automatic logic [15:0] enc2(input logic [6:0] v);
        logic [6:0] c;
        logic [3:0] t;
        logic [3:0] o;
        c = (v > 7'd99) ? 7'd99 : v;
        t = 4'(c / 7'd10);
        o = 4'(c % 7'd10);
        return {4'h3, t, 4'h3, o};
    endfunction

    assign hh = enc2(hour_q);
    assign mm = enc2(min_q);
    assign ss = enc2(sec_q);
    assign cc = enc2(msec_q);

    always_comb begin
        cur_byte = 8'h0A;
        case (idx_q)
            4'd0:    cur_byte = mode_q ? 8'h57 : 8'h53;
            4'd1:    cur_byte = hh[15:8];
            4'd2:    cur_byte = hh[7:0];
            4'd3:    cur_byte = 8'h3A;
            4'd4:    cur_byte = mm[15:8];
            4'd5:    cur_byte = mm[7:0];
            4'd6:    cur_byte = 8'h3A;
            4'd7:    cur_byte = ss[15:8];
            4'd8:    cur_byte = ss[7:0];
            4'd9:    cur_byte = 8'h2E;
            4'd10:   cur_byte = cc[15:8];
            4'd11:   cur_byte = cc[7:0];
            4'd12:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

`ifdef PERIODIC_REPORT_EN
    logic [6:0] sec_prev_q;
    logic       pend_q, pend_d;
    logic       trig;

    assign trig      = (i_sec != sec_prev_q);
    assign start_req = i_send | trig | pend_q;

    // A change seen while busy (DONE included) is remembered once.
    always_comb begin
        pend_d = pend_q;
        if (accept)
            pend_d = 1'b0;
        else if (trig && state_q != S_IDLE)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_prev_q <= 7'd0;
            pend_q     <= 1'b0;
        end else begin
            sec_prev_q <= i_sec;
            pend_q     <= pend_d;
        end
    end
`else
    assign start_req = i_send;
`endif

    assign accept   = (state_q == S_IDLE) && start_req;
    assign cnt_last = (cnt_q == CNT_LAST);
    assign nxt_bit  = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    idx_d   = 4'd0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nxt_bit;
                        tx_d  = cur_byte[nxt_bit];
                    end
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 4'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b0;
            hour_q <= 7'd0;
            min_q  <= 7'd0;
            sec_q  <= 7'd0;
            msec_q <= 7'd0;
        end else if (accept) begin
            mode_q <= i_mode;
            hour_q <= i_hour;
            min_q  <= i_min;
            sec_q  <= i_sec;
            msec_q <= i_msec;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_time_report_tx.sv
// Bench for time_report_tx: decodes the UART line bit by bit and compares
// each frame with a reference built from the field values.
module tb_time_report_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_send;
    logic       i_mode;
    logic [6:0] i_hour, i_min, i_sec, i_msec;
    logic       o_tx, o_busy, o_done;

    int tests = 0;
    int fails = 0;

    logic       ch_mode;
    logic [6:0] ch_hour, ch_min, ch_sec, ch_msec;
    logic       ch_send;

    logic [7:0] exp2 [14] = '{8'h57, 8'h31, 8'h32, 8'h3A, 8'h30, 8'h35,
                              8'h3A, 8'h30, 8'h39, 8'h2E, 8'h33, 8'h37,
                              8'h0D, 8'h0A};
    logic [7:0] ef [14];

    always #5 clk = ~clk;

    time_report_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_send (i_send),
        .i_mode (i_mode),
        .i_hour (i_hour),
        .i_min  (i_min),
        .i_sec  (i_sec),
        .i_msec (i_msec),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dig(input int v, input bit tens);
        int x;
        x = (v > 99) ? 99 : v;
        return 8'(tens ? 48 + x / 10 : 48 + x % 10);
    endfunction

    task automatic model(input logic m, input int h, input int mi,
                         input int s, input int c,
                         output logic [7:0] f [14]);
        f[0]  = m ? "W" : "S";
        f[1]  = dig(h, 1);  f[2]  = dig(h, 0);  f[3]  = ":";
        f[4]  = dig(mi, 1); f[5]  = dig(mi, 0); f[6]  = ":";
        f[7]  = dig(s, 1);  f[8]  = dig(s, 0);  f[9]  = ".";
        f[10] = dig(c, 1);  f[11] = dig(c, 0);
        f[12] = 8'h0D;      f[13] = 8'h0A;
    endtask

    task automatic set_time(input logic m, input int h, input int mi,
                            input int s, input int c);
        i_mode = m;
        i_hour = 7'(h); i_min = 7'(mi); i_sec = 7'(s); i_msec = 7'(c);
    endtask

    task automatic pulse_send();
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (o_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".started"}, 32'(o_busy), 32'd1);
    endtask

    // Entered on the first clock after accept; leaves on clock 1402.
    task automatic recv(input logic [7:0] exp [14], input int chg_at,
                        input string tag);
        logic [7:0] got [14];
        bit busy_ok, done_ok, frm_ok;
        int slot, w, b, j;
        busy_ok = 1; done_ok = 1; frm_ok = 1;
        for (int i = 0; i < 14; i++) got[i] = 8'h00;
        for (int c = 1; c <= 1402; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) chk({tag, ".start_low"}, 32'(o_tx), 32'd0);
            if (chg_at != 0 && c == chg_at) begin
                set_time(ch_mode, ch_hour, ch_min, ch_sec, ch_msec);
                i_send = ch_send;
            end
            if (chg_at != 0 && c == chg_at + 1) i_send = 1'b0;
            if (c <= 1400) begin
                slot = (c - 1) / 10;
                w = (c - 1) % 10;
                if (w == 4) begin
                    b = slot / 10;
                    j = slot % 10;
                    if (j == 0) begin
                        if (o_tx !== 1'b0) frm_ok = 0;
                    end else if (j == 9) begin
                        if (o_tx !== 1'b1) frm_ok = 0;
                    end else begin
                        got[b][j-1] = o_tx;
                    end
                end
                if (o_busy !== 1'b1) busy_ok = 0;
                if (o_done !== 1'b0) done_ok = 0;
            end else if (c == 1401) begin
                chk({tag, ".done_pulse"}, 32'(o_done), 32'd1);
                chk({tag, ".busy_in_done"}, 32'(o_busy), 32'd1);
            end else begin
                chk({tag, ".busy_clear"}, 32'(o_busy), 32'd0);
                chk({tag, ".done_clear"}, 32'(o_done), 32'd0);
            end
        end
        chk({tag, ".framing"}, 32'(frm_ok), 32'd1);
        chk({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        chk({tag, ".no_early_done"}, 32'(done_ok), 32'd1);
        for (int k = 0; k < 14; k++)
            chk($sformatf("%s.byte%0d", tag, k), 32'(got[k]), 32'(exp[k]));
    endtask

    task automatic idle_check(input int n, input string tag);
        bit ok;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tx !== 1'b1) ok = 0;
        end
        chk({tag, ".idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int h, mi, s, c;
        logic m;
        reset = 1'b1; i_send = 1'b0; ch_send = 1'b0;
        set_time(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst.tx", 32'(o_tx), 32'd1);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        reset = 1'b0;
        idle_check(50, "t1");

        set_time(1, 12, 5, 9, 37);
        pulse_send();
        recv(exp2, 0, "t2");
        idle_check(20, "t2");

        m = 1'($urandom_range(0, 1));
        h = $urandom_range(0, 23); mi = $urandom_range(0, 59);
        s = $urandom_range(0, 58); c = $urandom_range(0, 99);
        set_time(m, h, mi, s, c);
        model(m, h, mi, s, c, ef);
        ch_mode = m; ch_hour = 23; ch_min = 59; ch_sec = 59; ch_msec = 99;
        ch_send = 1'b1;
        pulse_send();
        recv(ef, 305, "t3");
        ch_send = 1'b0;
`ifdef PERIODIC_REPORT_EN
        wait_start("t3b");
        model(m, 23, 59, 59, 99, ef);
        recv(ef, 0, "t3b");
`endif
        idle_check(300, "t3");

        set_time(0, 120, 0, 0, 0);
        model(0, 120, 0, 0, 0, ef);
        pulse_send();
        recv(ef, 0, "t4");

        for (int r = 0; r < 3; r++) begin
            m = 1'($urandom_range(0, 1));
            h = $urandom_range(0, 127); mi = $urandom_range(0, 127);
            s = $urandom_range(0, 127); c = $urandom_range(0, 127);
            set_time(m, h, mi, s, c);
            model(m, h, mi, s, c, ef);
            pulse_send();
            recv(ef, 0, $sformatf("rnd%0d", r));
        end

        m = 1'($urandom_range(0, 1));
        h = $urandom_range(0, 23); mi = $urandom_range(0, 59);
        c = $urandom_range(0, 99);
        set_time(m, h, mi, 0, c);
        model(m, h, mi, 0, c, ef);
        pulse_send();
        repeat (654) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5.rst_tx", 32'(o_tx), 32'd1);
        chk("t5.rst_busy", 32'(o_busy), 32'd0);
        chk("t5.rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_check(200, "t5");
        pulse_send();
        recv(ef, 0, "t5b");

`ifdef PERIODIC_REPORT_EN
        i_sec = 7'd9;
        wait_start("t6a");
        model(m, h, mi, 9, c, ef);
        recv(ef, 0, "t6a");
        i_sec = 7'd10;
        wait_start("t6b");
        model(m, h, mi, 10, c, ef);
        ch_mode = m; ch_hour = 7'(h); ch_min = 7'(mi); ch_sec = 7'd11;
        ch_msec = 7'(c); ch_send = 1'b0;
        recv(ef, 305, "t6b");
        wait_start("t6c");
        model(m, h, mi, 11, c, ef);
        recv(ef, 0, "t6c");
        idle_check(50, "t6");
`else
        i_sec = 7'd9;
        idle_check(20, "t6a");
        i_sec = 7'd10;
        idle_check(50, "t6b");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
